// File: rtl/uart_rx_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_dispatcher
//
// Drains the UART RX frame FIFO one 40-bit frame at a time. Each frame is
// {dest[3:0], type[3:0], payload[31:0]}. The payload and type are handed to
// consumer <dest> over a req/ack handshake. Invalid destinations and consumer
// timeouts become error frames {8'hFE, code, header, payload[15:0]}, which are
// written to the TX control FIFO so that the host gets a reply.
//
// Optional feature macro: DISPATCH_BROADCAST_EN
//   When defined, dest 0xF raises every Dest_Req bit. Each bit drops on its
//   own ack. A timeout reports code 0x03 with the missing-ack mask in the
//   low bits of the error frame. When the macro is undefined, dest 0xF is
//   an ordinary invalid id (code 0x01).
//
// Parameters:
//   NUM_DEST        number of consumer ports (1..15)
//   TIMEOUT_CYCLES  cycles a request may wait for its ack (>= 2)
//
// Ports:
//   Clock, Reset    logic clock, asynchronous active-high reset
//   RX_Fifo_Empty   RX FIFO empty flag
//   RX_Fifo_RE      RX FIFO read strobe (Q is valid the cycle after)
//   RX_Fifo_Data    RX FIFO Q, 40-bit frame
//   Dest_Req        one-hot request, held until ack or timeout
//   Dest_Type       latched header[3:0]
//   Dest_Data       latched payload[31:0]
//   Dest_Ack        per-consumer acknowledge (pulse or level)
//   Err_Fifo_WE     TX control FIFO write strobe
//   Err_Fifo_Data   error frame, stable while in ERROR
//   Err_Fifo_Full   TX control FIFO full flag
//   Busy            high whenever the FSM is not idle
//   Frame_Count     frames acked (wrapping)
//   Error_Count     error frames written (saturating)
// ---------------------------------------------------------------------------
module uart_rx_cmd_dispatcher #(
    parameter int NUM_DEST       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                RX_Fifo_Empty,
    output logic                RX_Fifo_RE,
    input  logic [39:0]         RX_Fifo_Data,
    output logic [NUM_DEST-1:0] Dest_Req,
    output logic [3:0]          Dest_Type,
    output logic [31:0]         Dest_Data,
    input  logic [NUM_DEST-1:0] Dest_Ack,
    output logic                Err_Fifo_WE,
    output logic [39:0]         Err_Fifo_Data,
    input  logic                Err_Fifo_Full,
    output logic                Busy,
    output logic [15:0]         Frame_Count,
    output logic [15:0]         Error_Count
);

    localparam int         TMO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] NUM_DEST_W = 4'(NUM_DEST);
`ifdef DISPATCH_BROADCAST_EN
    localparam logic [15:0] DEST_MASK = 16'((1 << NUM_DEST) - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LATCH,
        ST_DISPATCH,
        ST_ERROR
    } state_t;

    state_t              state;
    logic [39:0]         frame_q;
    logic [TMO_W-1:0]    tmo_cnt;
`ifdef DISPATCH_BROADCAST_EN
    logic                is_bcast;
`endif

    logic [3:0]          rx_dest;
    logic                rx_ok;
    logic [NUM_DEST-1:0] rx_req;
    logic [NUM_DEST-1:0] remaining;
    logic [7:0]          tmo_code;
    logic [15:0]         tmo_low;

    assign rx_dest = RX_Fifo_Data[39:36];

    // Requests still waiting for an ack. A one-hot request drops only on
    // the ack of its own bit, so acks on other bits leave it untouched.
    assign remaining = Dest_Req & ~Dest_Ack;

    // Decode the incoming header into the request vector to raise.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_req = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            rx_req[i] = (rx_dest == 4'(i));
        end
        rx_ok = (rx_dest < NUM_DEST_W);
`ifdef DISPATCH_BROADCAST_EN
        if (rx_dest == 4'hF) begin
            rx_req = '1;
            rx_ok  = 1'b1;
        end
`endif
    end

    // Error code and low half-word reported when a request times out.
    always_comb begin
        tmo_code = 8'h02;
        tmo_low  = frame_q[15:0];
`ifdef DISPATCH_BROADCAST_EN
        if (is_bcast) begin
            tmo_code = 8'h03;
            tmo_low  = (frame_q[15:0] & ~DEST_MASK) | 16'(remaining);
        end
`endif
    end

    // The two FIFO strobes are decoded from the state so that each one is
    // qualified by the flag of the same cycle. A registered strobe would
    // act on a flag that is one cycle old and could overrun or underrun.
    // Reset gates RE because the state already reads IDLE during reset.
    assign RX_Fifo_RE  = (state == ST_IDLE) && !RX_Fifo_Empty && !Reset;
    assign Err_Fifo_WE = (state == ST_ERROR) && !Err_Fifo_Full;
    assign Busy        = (state != ST_IDLE);

    assign Dest_Type = frame_q[35:32];
    assign Dest_Data = frame_q[31:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block samples the values from before the clock edge.
    // NOTE: the asynchronous reset clears every register, including the
    // latched frame, so no stale payload survives a reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= ST_IDLE;
            frame_q       <= '0;
            tmo_cnt       <= '0;
            Dest_Req      <= '0;
            Err_Fifo_Data <= '0;
            Frame_Count   <= '0;
            Error_Count   <= '0;
`ifdef DISPATCH_BROADCAST_EN
            is_bcast      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!RX_Fifo_Empty) begin
                        state <= ST_READ;
                    end
                end

                ST_READ: begin
                    state <= ST_LATCH;
                end

                ST_LATCH: begin
                    frame_q <= RX_Fifo_Data;
                    tmo_cnt <= '0;
`ifdef DISPATCH_BROADCAST_EN
                    is_bcast <= (rx_dest == 4'hF);
`endif
                    if (rx_ok) begin
                        Dest_Req <= rx_req;
                        state    <= ST_DISPATCH;
                    end else begin
                        Err_Fifo_Data <= {8'hFE, 8'h01, RX_Fifo_Data[39:32],
                                          RX_Fifo_Data[15:0]};
                        state         <= ST_ERROR;
                    end
                end

                ST_DISPATCH: begin
                    // An ack in the expiry cycle is checked first, so it wins.
                    if (remaining == '0) begin
                        Dest_Req    <= '0;
                        Frame_Count <= Frame_Count + 16'd1;
                        state       <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        Dest_Req      <= '0;
                        Err_Fifo_Data <= {8'hFE, tmo_code, frame_q[39:32], tmo_low};
                        state         <= ST_ERROR;
                    end else begin
                        Dest_Req <= remaining;
                        tmo_cnt  <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_ERROR: begin
                    // Hold the error frame while the TX FIFO is full and never drop it.
                    if (!Err_Fifo_Full) begin
                        if (Error_Count != 16'hFFFF) begin
                            Error_Count <= Error_Count + 16'd1;
                        end
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cmd_dispatcher
//
// Directed bench for uart_rx_cmd_dispatcher with NUM_DEST=4 and
// TIMEOUT_CYCLES=16. The RX FIFO is modelled as a small array with a
// one-cycle registered Q. Consumers ack either from a directed drive or
// immediately through a per-bit auto-ack mask. The broadcast step follows
// DISPATCH_BROADCAST_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx_cmd_dispatcher;

    localparam int NUM_DEST       = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                Clock = 1'b0;
    logic                Reset;
    logic                RX_Fifo_Empty;
    logic                RX_Fifo_RE;
    logic [39:0]         RX_Fifo_Data;
    logic [NUM_DEST-1:0] Dest_Req;
    logic [3:0]          Dest_Type;
    logic [31:0]         Dest_Data;
    logic [NUM_DEST-1:0] Dest_Ack;
    logic                Err_Fifo_WE;
    logic [39:0]         Err_Fifo_Data;
    logic                Err_Fifo_Full;
    logic                Busy;
    logic [15:0]         Frame_Count;
    logic [15:0]         Error_Count;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    uart_rx_cmd_dispatcher #(
        .NUM_DEST       (NUM_DEST),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .RX_Fifo_Empty (RX_Fifo_Empty),
        .RX_Fifo_RE    (RX_Fifo_RE),
        .RX_Fifo_Data  (RX_Fifo_Data),
        .Dest_Req      (Dest_Req),
        .Dest_Type     (Dest_Type),
        .Dest_Data     (Dest_Data),
        .Dest_Ack      (Dest_Ack),
        .Err_Fifo_WE   (Err_Fifo_WE),
        .Err_Fifo_Data (Err_Fifo_Data),
        .Err_Fifo_Full (Err_Fifo_Full),
        .Busy          (Busy),
        .Frame_Count   (Frame_Count),
        .Error_Count   (Error_Count)
    );

    // RX FIFO model: Q updates on the edge that samples RE.
    logic [39:0] rx_mem [0:15];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic [39:0] rx_q   = '0;

    assign RX_Fifo_Empty = (wr_ptr == rd_ptr);
    assign RX_Fifo_Data  = rx_q;

    always @(posedge Clock) begin
        if (RX_Fifo_RE) begin
            rx_q   <= rx_mem[rd_ptr[3:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Consumers: a directed ack drive plus an immediate auto-ack per bit.
    logic [NUM_DEST-1:0] ack_drv  = '0;
    logic [NUM_DEST-1:0] ack_auto = '0;
    assign Dest_Ack = ack_drv | (Dest_Req & ack_auto);

    // Monitor, sampled on the falling edge. It only accumulates. The
    // directed sequence takes snapshots and compares the differences.
    int          cyc       = 0;
    int          req_hi    = 0;
    int          multi_req = 0;
    int          we_cnt    = 0;
    int          we_full   = 0;
    int          re_empty  = 0;
    int          re_cyc [$];
    logic [31:0] acked  [$];

    always @(negedge Clock) begin
        cyc <= cyc + 1;
        if (RX_Fifo_RE) re_cyc.push_back(cyc);
        if (RX_Fifo_RE && RX_Fifo_Empty) re_empty <= re_empty + 1;
        if (|Dest_Req) req_hi <= req_hi + 1;
        if ($countones(Dest_Req) > 1) multi_req <= multi_req + 1;
        if (Err_Fifo_WE) we_cnt <= we_cnt + 1;
        if (Err_Fifo_WE && Err_Fifo_Full) we_full <= we_full + 1;
        if (|(Dest_Req & Dest_Ack)) acked.push_back(Dest_Data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic push(input logic [39:0] f);
        rx_mem[wr_ptr[3:0]] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (Dest_Req == '0 && n < 40) begin
            tick(1);
            n++;
        end
        check({tag, "_req_wait"}, 64'(Dest_Req != '0), 64'd1);
    endtask

    task automatic wait_we(input string tag);
        int n = 0;
        while (!Err_Fifo_WE && n < 60) begin
            tick(1);
            n++;
        end
        check({tag, "_we_wait"}, 64'(Err_Fifo_WE), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int w0;
        int m0;
        int q0;
        int a0;

        Reset         = 1'b1;
        Err_Fifo_Full = 1'b0;
        tick(3);

        // Reset state, with a frame already waiting in the FIFO.
        push(40'h1_3_DEADBEEF);
        #1;
        check("rst_re",      RX_Fifo_RE,    0);
        check("rst_req",     Dest_Req,      0);
        check("rst_we",      Err_Fifo_WE,   0);
        check("rst_busy",    Busy,          0);
        check("rst_fcnt",    Frame_Count,   0);
        check("rst_ecnt",    Error_Count,   0);
        check("rst_errdata", Err_Fifo_Data, 0);
        check("rst_type",    Dest_Type,     0);
        check("rst_data",    Dest_Data,     0);
        tick(1);
        Reset = 1'b0;

        // 1: valid frame to dest 1, ack two cycles after the request.
        r0 = req_hi;
        w0 = we_cnt;
        wait_req("d1");
        check("d1_req",  Dest_Req,  4'b0010);
        check("d1_type", Dest_Type, 4'h3);
        check("d1_data", Dest_Data, 32'hDEADBEEF);
        tick(2);
        ack_drv = 4'b0010;
        tick(1);
        ack_drv = '0;
        check("d1_req_drop", Dest_Req,    0);
        check("d1_fcnt",     Frame_Count, 1);
        check("d1_busy",     Busy,        0);
        check("d1_req_len",  req_hi - r0, 3);
        check("d1_no_we",    we_cnt - w0, 0);

        // 2: invalid destination 9 -> error code 0x01.
        r0 = req_hi;
        push(40'h9_5_00001234);
        wait_we("inv");
        check("inv_errdata", Err_Fifo_Data, 40'hFE_01_95_1234);
        tick(1);
        check("inv_ecnt",   Error_Count, 1);
        check("inv_busy",   Busy,        0);
        check("inv_no_req", req_hi - r0, 0);

        // 3: dest 2 never acks -> request held 16 cycles, then code 0x02.
        r0 = req_hi;
        push(40'h2_A_CAFEF00D);
        wait_we("tmo");
        check("tmo_req_len", req_hi - r0,   16);
        check("tmo_errdata", Err_Fifo_Data, 40'hFE_02_2A_F00D);
        check("tmo_req_off", Dest_Req,      0);
        tick(1);
        check("tmo_ecnt", Error_Count, 2);

        // 4: timeout while the TX FIFO is full for 10 cycles.
        Err_Fifo_Full = 1'b1;
        r0 = req_hi;
        push(40'h3_7_12345678);
        wait_req("full");
        tick(16);
        w0 = we_cnt;
        check("full_busy",    Busy,          1);
        check("full_we0",     Err_Fifo_WE,   0);
        check("full_errdata", Err_Fifo_Data, 40'hFE_02_37_5678);
        tick(10);
        check("full_we_held", we_cnt - w0,   0);
        check("full_hold",    Err_Fifo_Data, 40'hFE_02_37_5678);
        Err_Fifo_Full = 1'b0;
        #1;
        check("full_we1",      Err_Fifo_WE,   1);
        check("full_release",  Err_Fifo_Data, 40'hFE_02_37_5678);
        tick(1);
        check("full_one_pulse", we_cnt - w0,   1);
        check("full_ecnt",      Error_Count,   3);
        check("full_busy_end",  Busy,          0);
        check("full_req_len",   req_hi - r0,   16);

        // 5: three back-to-back frames, immediate acks.
        ack_auto = '1;
        m0 = multi_req;
        q0 = re_cyc.size();
        a0 = acked.size();
        push(40'h0_1_00000001);
        push(40'h3_2_00000002);
        push(40'h2_4_00000003);
        tick(16);
        check("b2b_re_n", re_cyc.size() - q0, 3);
        if (re_cyc.size() - q0 == 3) begin
            check("b2b_gap1", re_cyc[q0 + 1] - re_cyc[q0],     4);
            check("b2b_gap2", re_cyc[q0 + 2] - re_cyc[q0 + 1], 4);
        end
        check("b2b_ack_n", acked.size() - a0, 3);
        if (acked.size() - a0 == 3) begin
            check("b2b_data0", acked[a0],     32'h00000001);
            check("b2b_data1", acked[a0 + 1], 32'h00000002);
            check("b2b_data2", acked[a0 + 2], 32'h00000003);
        end
        check("b2b_onehot", multi_req - m0, 0);
        check("b2b_fcnt",   Frame_Count,    4);
        check("b2b_busy",   Busy,           0);

        // 6: reset during DISPATCH, then a normal frame.
        ack_auto = '0;
        push(40'h1_2_0BADF00D);
        wait_req("mid");
        Reset = 1'b1;
        #1;
        check("mid_req",  Dest_Req,    0);
        check("mid_busy", Busy,        0);
        check("mid_fcnt", Frame_Count, 0);
        check("mid_ecnt", Error_Count, 0);
        tick(2);
        Reset    = 1'b0;
        ack_auto = '1;
        push(40'h2_6_13572468);
        wait_req("post");
        check("post_req",  Dest_Req,  4'b0100);
        check("post_type", Dest_Type, 4'h6);
        check("post_data", Dest_Data, 32'h13572468);
        tick(1);
        check("post_fcnt", Frame_Count, 1);
        check("post_busy", Busy,        0);

`ifdef DISPATCH_BROADCAST_EN
        // 7: broadcast acked on bits 0,1,3 only -> code 0x03, mask 4'b0100.
        ack_auto = 4'b1011;
        push(40'hF_9_0000ABCD);
        wait_req("bc");
        check("bc_req_all", Dest_Req, 4'b1111);
        wait_we("bc");
        check("bc_errdata", Err_Fifo_Data, 40'hFE_03_F9_ABC4);
        check("bc_req_off", Dest_Req,      0);
        tick(1);
        check("bc_ecnt", Error_Count, 1);
        // Broadcast fully acked completes as one frame.
        ack_auto = '1;
        push(40'hF_2_00000055);
        wait_req("bc_ok");
        check("bc_ok_req", Dest_Req, 4'b1111);
        tick(1);
        check("bc_ok_fcnt", Frame_Count, 2);
        check("bc_ok_busy", Busy,        0);
`else
        // 7: dest 0xF is an ordinary invalid id -> code 0x01.
        ack_auto = '1;
        r0 = req_hi;
        push(40'hF_1_0000ABCD);
        wait_we("df");
        check("df_errdata", Err_Fifo_Data, 40'hFE_01_F1_ABCD);
        tick(1);
        check("df_ecnt",   Error_Count, 1);
        check("df_no_req", req_hi - r0, 0);
`endif

        // Whole-run protocol properties.
        check("we_while_full",  we_full,  0);
        check("re_while_empty", re_empty, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
